// File: rtl/pwm_demodulator.sv
// PWM demodulator: measures the period and high time of an asynchronous PWM
// stream between consecutive rising edges. It recovers the modulating sample
// that a triangle-carrier comparator would have produced. An input that stops
// toggling for TIMEOUT clocks is reported as stuck high or stuck low.
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | no period in progress; waiting for a rising edge to start one
// MEAS  | counting period and high clocks since the last rising edge
module pwm_demodulator #(
    parameter int WIDTH_TRIANG = 6,
    parameter int CNT_W        = 8,
    parameter int TIMEOUT      = 255
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    pwm_in,
    output logic [CNT_W-1:0]        duty,
    output logic [CNT_W-1:0]        period,
    output logic [WIDTH_TRIANG-1:0] sample,
    output logic                    valid,
    output logic                    stuck_hi,
    output logic                    stuck_lo
);

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] MEAS = 1'b1;

    localparam logic [CNT_W-1:0] TIMEOUT_CNT = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);
    localparam logic [CNT_W:0]   SAMPLE_MAX  = (CNT_W+1)'((1 << WIDTH_TRIANG) - 1);

    logic                    s1, s2, s3;
    logic                    rise;
    logic                    timeout;
    logic [0:0]              state;
    logic [CNT_W-1:0]        period_cnt;
    logic [CNT_W-1:0]        high_cnt;
    logic [CNT_W:0]          half_cnt;
    logic [WIDTH_TRIANG-1:0] sample_next;

    // Two-flop synchronizer plus a history flop for rising-edge detection.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
            s3 <= 1'b0;
        end else begin
            s1 <= pwm_in;
            s2 <= s1;
            s3 <= s2;
        end
    end

    assign rise    = s2 & ~s3;
    assign timeout = (period_cnt == TIMEOUT_CNT);

    // A comparator that is high when value > carrier stays high for 2s-1 clocks.
    // Rounding (high+1)/2 therefore inverts it, saturated to the sample range.
    always_comb begin
        half_cnt = ({1'b0, high_cnt} + (CNT_W+1)'(1)) >> 1;
        if (half_cnt > SAMPLE_MAX) begin
            sample_next = '1;
        end else begin
            sample_next = half_cnt[WIDTH_TRIANG-1:0];
        end
    end

    // Measurement FSM: counters, registered results and the one-cycle valid strobe.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            period_cnt <= '0;
            high_cnt   <= '0;
            duty       <= '0;
            period     <= '0;
            sample     <= '0;
            valid      <= 1'b0;
            stuck_hi   <= 1'b0;
            stuck_lo   <= 1'b0;
        end else begin
            valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (rise) begin
                        state      <= MEAS;
                        period_cnt <= CNT_ONE;
                        high_cnt   <= CNT_ONE;
                    end
                end
                MEAS: begin
                    // A rise wins over a coincident timeout.
                    if (rise) begin
                        duty       <= high_cnt;
                        period     <= period_cnt;
                        sample     <= sample_next;
                        stuck_hi   <= 1'b0;
                        stuck_lo   <= 1'b0;
                        valid      <= 1'b1;
                        period_cnt <= CNT_ONE;
                        high_cnt   <= CNT_ONE;
                    end else if (timeout) begin
                        // Report once, then park in IDLE so a constant input stays quiet.
                        valid  <= 1'b1;
                        period <= '0;
                        if (s2) begin
                            duty     <= '1;
                            sample   <= '1;
                            stuck_hi <= 1'b1;
                            stuck_lo <= 1'b0;
                        end else begin
                            duty     <= '0;
                            sample   <= '0;
                            stuck_hi <= 1'b0;
                            stuck_lo <= 1'b1;
                        end
                        state <= IDLE;
                    end else begin
                        period_cnt <= period_cnt + CNT_ONE;
                        high_cnt   <= high_cnt + CNT_W'(s2);
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pwm_demodulator.sv
// Testbench for pwm_demodulator. It drives directed and randomized PWM streams.
// A stream-level reference predicts each report from the distances between
// input rising edges. Every registered output is compared against it on every
// cycle.
module tb_pwm_demodulator;

    localparam int WT      = 6;
    localparam int CW      = 8;
    localparam int TO      = 255;
    localparam int CARRIER = 2 * ((1 << WT) - 1);
    localparam int OW      = 2 * CW + WT + 2;
    localparam int LAT     = 2;

    logic          clk = 1'b0;
    logic          rst;
    logic          pwm_in;
    logic [CW-1:0] duty;
    logic [CW-1:0] period;
    logic [WT-1:0] sample;
    logic          valid;
    logic          stuck_hi;
    logic          stuck_lo;

    pwm_demodulator #(.WIDTH_TRIANG(WT), .CNT_W(CW), .TIMEOUT(TO)) dut (
        .clk      (clk),
        .rst      (rst),
        .pwm_in   (pwm_in),
        .duty     (duty),
        .period   (period),
        .sample   (sample),
        .valid    (valid),
        .stuck_hi (stuck_hi),
        .stuck_lo (stuck_lo)
    );

    always #5 clk = ~clk;

    typedef struct {
        int due;
        int period;
        int duty;
        int sample;
        bit shi;
        bit slo;
    } rep_t;

    rep_t expq[$];
    rep_t held;
    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;

    // Reference state: input samples since the last accepted rising edge.
    bit   in_meas;
    bit   prev;
    bit   win[$];

    function automatic logic [OW-1:0] pack(input rep_t r);
        return {CW'(r.duty), CW'(r.period), WT'(r.sample), r.shi, r.slo};
    endfunction

    function automatic int ones_in_window();
        int n = 0;
        foreach (win[i]) n += int'(win[i]);
        return n;
    endfunction

    task automatic model_reset();
        expq.delete();
        held    = '{default: 0};
        prev    = 1'b0;
        in_meas = 1'b0;
        win.delete();
    endtask

    task automatic model_sample(input bit x);
        rep_t r;
        bit   is_rise;
        int   smax;
        smax    = (1 << WT) - 1;
        is_rise = x && !prev;
        r       = '{default: 0};
        r.due   = cyc + LAT;
        if (in_meas && win.size() == TO && !is_rise) begin
            r.period = 0;
            r.duty   = x ? (1 << CW) - 1 : 0;
            r.sample = x ? smax : 0;
            r.shi    = x;
            r.slo    = !x;
            expq.push_back(r);
            in_meas = 1'b0;
            win.delete();
        end else if (is_rise) begin
            if (in_meas) begin
                r.period = win.size();
                r.duty   = ones_in_window();
                r.sample = ((r.duty + 1) / 2 > smax) ? smax : (r.duty + 1) / 2;
                expq.push_back(r);
            end
            in_meas = 1'b1;
            win.delete();
        end
        if (in_meas) win.push_back(x);
        prev = x;
    endtask

    task automatic check_outputs();
        rep_t           r;
        logic [OW-1:0]  obs;
        obs = {duty, period, sample, stuck_hi, stuck_lo};
        if (expq.size() > 0 && expq[0].due == cyc) begin
            r = expq.pop_front();
            checks++;
            assert (valid === 1'b1) else begin
                failures++;
                $error("FAIL valid_strobe cyc=%0d observed=%b expected=1", cyc, valid);
            end
            checks++;
            assert (obs === pack(r)) else begin
                failures++;
                $error("FAIL report_fields cyc=%0d observed=%h expected=%h", cyc, obs, pack(r));
            end
            held = r;
        end else begin
            checks++;
            assert (valid === 1'b0) else begin
                failures++;
                $error("FAIL idle_valid cyc=%0d observed=%b expected=0", cyc, valid);
            end
            checks++;
            assert (obs === pack(held)) else begin
                failures++;
                $error("FAIL hold_outputs cyc=%0d observed=%h expected=%h", cyc, obs, pack(held));
            end
        end
    endtask

    task automatic step(input bit x);
        pwm_in = x;
        @(posedge clk);
        cyc++;
        if (rst) begin
            prev    = 1'b0;
            in_meas = 1'b0;
            win.delete();
        end else begin
            model_sample(x);
        end
        @(negedge clk);
        check_outputs();
    endtask

    task automatic reset_pulse(input int n, input bit toggle);
        rst = 1'b1;
        model_reset();
        for (int i = 0; i < n; i++) step(toggle ? bit'(i % 2) : pwm_in);
        rst = 1'b0;
    endtask

    task automatic carrier(input int s, input int t0, input int n);
        for (int i = 0; i < n; i++) begin
            int t;
            int c;
            t = (t0 + i) % CARRIER;
            c = (t <= CARRIER / 2) ? t : CARRIER - t;
            step(s > c);
        end
    endtask

    task automatic hold_level(input bit lvl, input int n);
        for (int i = 0; i < n; i++) step(lvl);
    endtask

    task automatic pulse(input int hi, input int lo);
        hold_level(1'b1, hi);
        hold_level(1'b0, lo);
    endtask

    initial begin
        rst    = 1'b0;
        pwm_in = 1'b0;
        model_reset();
        #2;
        // Reset with a toggling input: everything must read zero.
        reset_pulse(10, 1'b1);

        // Mid-scale carrier, then both extremes.
        carrier(32, 0, CARRIER * 4);
        carrier(1, 0, CARRIER * 3);
        carrier(63, 0, CARRIER * 3);

        // Stuck low after a measurement, then recovery.
        hold_level(1'b0, 300);
        carrier(32, 0, CARRIER * 3);

        // Stuck high, then recovery at mid-scale.
        hold_level(1'b1, 300);
        carrier(32, 0, CARRIER * 3);

        // Reset 40 clocks after a rise (rise sits at t=95 for s=32).
        carrier(32, 0, CARRIER * 2 + 95 + 40);
        reset_pulse(3, 1'b0);
        carrier(32, 12, CARRIER * 3);

        // Randomized modulation values.
        for (int k = 0; k < 6; k++) begin
            carrier(int'($urandom_range(0, 63)), 0, CARRIER * 2);
        end

        // Randomized pulse trains shorter than the timeout.
        for (int k = 0; k < 20; k++) begin
            pulse(int'($urandom_range(1, 120)), int'($urandom_range(1, 120)));
        end

        // Rise exactly at the timeout count, then one clock past it.
        pulse(1, TO - 1);
        pulse(1, TO);
        pulse(1, 10);
        pulse(5, 10);
        pulse(3, 7);
        hold_level(1'b0, 6);

        checks++;
        assert (expq.size() == 0) else begin
            failures++;
            $error("FAIL queue_drained observed=%0d expected=0", expq.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
